// File: rtl/montre_nios2_qsys_0_oci_trace_capture.sv
// Trace capture buffer: stores nonzero-count trace frames {dct_count, dct_buffer}
// in a DEPTH-entry circular buffer under a small IDLE/CAPTURE/DRAIN/DONE FSM.
// Latency: a write shows on rd_valid/rd_data the next cycle.
// Backpressure: show-ahead read, pop on rd_valid & rd_ready. When full with no
// pop, the frame is dropped (WRAP_MODE=0) or overwrites the oldest entry
// (WRAP_MODE=1). Either way the sticky overflow flag is set.
// Ports: clk, reset_n (sync, active-low); dct_valid/dct_buffer/dct_count frame input;
// test_ending/test_has_ended capture control; rd_valid/rd_ready/rd_data read side;
// level, overflow, state, done status.
module montre_nios2_qsys_0_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      dct_valid,
  input  logic [DATA_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]          dct_count,
  input  logic                      test_ending,
  input  logic                      test_has_ended,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [CNT_W+DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [1:0]                state,
  output logic                      done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [CNT_W+DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;

  logic stop;
  logic full;
  logic pop;
  logic wr_req;   // a frame that qualifies for storage this cycle
  logic wr_en;    // the frame actually lands in memory
  logic rd_adv;   // read pointer moves (pop, or overwrite of oldest)
  logic lvl_inc;
  logic lvl_dec;

  always_comb begin
    stop   = test_ending | test_has_ended;
    full   = (level == LVL_FULL);
    pop    = rd_valid & rd_ready;
    // IDLE only accepts the frame that starts the capture; a stop in the
    // same cycle sends IDLE straight to DRAIN with nothing stored.
    wr_req = dct_valid && (dct_count != '0) &&
             ((state == S_CAPTURE) || ((state == S_IDLE) && !stop));
    // Full with a concurrent pop frees a slot first, so the write still fits.
    wr_en  = wr_req && (!full || pop || (WRAP_MODE != 0));
    rd_adv = pop || (wr_req && full && (WRAP_MODE != 0));
    // Level only moves for a write into free space with no pop, or a pop with
    // no write; every full-buffer case leaves it at DEPTH.
    lvl_inc = wr_req && !full && !pop;
    lvl_dec = pop && !wr_req;
  end

  // Outputs come only from registered state, never directly from inputs.
  always_comb begin
    rd_valid = (level != '0);
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
    done     = (state == S_DONE);
  end

  // Storage is not reset; rd_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      mem[wr_ptr] <= {dct_count, dct_buffer};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (lvl_inc) begin
        level <= level + LVL_ONE;
      end else if (lvl_dec) begin
        level <= level - LVL_ONE;
      end
      if (wr_req && full && !pop) begin
        overflow <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (stop) begin
            state <= S_DRAIN;
          end else if (dct_valid && (dct_count != '0)) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (stop) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((level == '0) && test_has_ended) begin
            state <= S_DONE;
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_montre_nios2_qsys_0_oci_trace_capture.sv
// Directed bench for the trace capture buffer. Two instances share stimulus:
// u_w0 drops on full, u_w1 overwrites the oldest entry on full.
module tb_montre_nios2_qsys_0_oci_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dct_valid = 1'b0;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        test_ending = 1'b0;
  logic        test_has_ended = 1'b0;
  logic        rd_ready = 1'b0;

  logic        rd_valid_w0, rd_valid_w1;
  logic [33:0] rd_data_w0, rd_data_w1;
  logic [4:0]  level_w0, level_w1;
  logic        overflow_w0, overflow_w1;
  logic [1:0]  state_w0, state_w1;
  logic        done_w0, done_w1;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  montre_nios2_qsys_0_oci_trace_capture #(.WRAP_MODE(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rd_valid_w0), .rd_data(rd_data_w0),
    .level(level_w0), .overflow(overflow_w0), .state(state_w0), .done(done_w0));

  montre_nios2_qsys_0_oci_trace_capture #(.WRAP_MODE(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rd_valid_w1), .rd_data(rd_data_w1),
    .level(level_w1), .overflow(overflow_w1), .state(state_w1), .done(done_w1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] ent(input int c, input int d);
    logic [3:0]  cc;
    logic [29:0] dd;
    cc = c[3:0];
    dd = d[29:0];
    return {cc, dd};
  endfunction

  task automatic frame(input int c, input int d);
    dct_valid  = 1'b1;
    dct_count  = c[3:0];
    dct_buffer = d[29:0];
    tick();
    dct_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_state", state_w0, 0);
    chk("rst_level", level_w0, 0);
    chk("rst_rd_valid", rd_valid_w0, 0);
    chk("rst_rd_data", rd_data_w0, 0);
    chk("rst_overflow", overflow_w0, 0);
    chk("rst_done", done_w0, 0);
    reset_n = 1'b1;

    // Three frames, then drain in order
    frame(1, 1);
    chk("a_first_level", level_w0, 1);
    chk("a_first_rd_valid", rd_valid_w0, 1);
    chk("a_first_state", state_w0, 1);
    frame(2, 2);
    frame(3, 3);
    chk("a_level3", level_w0, 3);
    chk("a_state_capture", state_w0, 1);
    chk("a_head", rd_data_w0, ent(1, 1));
    rd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("a_pop_data", rd_data_w0, ent(i, i));
      tick();
    end
    rd_ready = 1'b0;
    chk("a_empty_level", level_w0, 0);
    chk("a_empty_rd_valid", rd_valid_w0, 0);
    chk("a_empty_rd_data", rd_data_w0, 0);

    // 17 frames into 16 slots: drop vs overwrite
    do_reset();
    for (int i = 0; i <= 15; i++) frame(1, i);
    chk("b_full_no_ovf", overflow_w0, 0);
    frame(1, 16);
    chk("b_level_w0", level_w0, 16);
    chk("b_level_w1", level_w1, 16);
    chk("b_ovf_w0", overflow_w0, 1);
    chk("b_ovf_w1", overflow_w1, 1);
    rd_ready = 1'b1;
    for (int i = 0; i <= 15; i++) begin
      chk("b_read_w0", rd_data_w0, ent(1, i));
      chk("b_read_w1", rd_data_w1, ent(1, i + 1));
      tick();
    end
    rd_ready = 1'b0;
    chk("b_drained", level_w0, 0);
    chk("b_ovf_sticky", overflow_w0, 1);

    // Full buffer: write + pop together, then write with no pop
    do_reset();
    for (int i = 0; i <= 15; i++) frame(2, 'h100 + i);
    chk("c_full_level", level_w0, 16);
    chk("c_head_before", rd_data_w0, ent(2, 'h100));
    rd_ready = 1'b1;
    frame(2, 'h155);
    rd_ready = 1'b0;
    chk("c_wp_level_w0", level_w0, 16);
    chk("c_wp_level_w1", level_w1, 16);
    chk("c_wp_ovf_w0", overflow_w0, 0);
    chk("c_wp_ovf_w1", overflow_w1, 0);
    chk("c_wp_head", rd_data_w0, ent(2, 'h101));
    frame(2, 'h166);
    chk("c_drop_ovf", overflow_w0, 1);
    chk("c_drop_level", level_w0, 16);
    chk("c_drop_head", rd_data_w0, ent(2, 'h101));
    chk("c_wrap_ovf", overflow_w1, 1);
    chk("c_wrap_head", rd_data_w1, ent(2, 'h102));

    // Stop with a frame in the same cycle, then drain to DONE
    do_reset();
    frame(1, 'hA);
    test_ending = 1'b1;
    frame(1, 'hB);
    chk("d_state_drain", state_w0, 2);
    chk("d_level2", level_w0, 2);
    frame(1, 'hC);
    chk("d_ignored_level", level_w0, 2);
    chk("d_ignored_ovf", overflow_w0, 0);
    test_has_ended = 1'b1;
    tick();
    chk("d_wait_drain", state_w0, 2);
    rd_ready = 1'b1;
    chk("d_pop_a", rd_data_w0, ent(1, 'hA));
    tick();
    chk("d_pop_b", rd_data_w0, ent(1, 'hB));
    tick();
    rd_ready = 1'b0;
    chk("d_empty", level_w0, 0);
    chk("d_still_drain", state_w0, 2);
    tick();
    chk("d_state_done", state_w0, 3);
    chk("d_done", done_w0, 1);
    test_ending = 1'b0;
    test_has_ended = 1'b0;
    tick();
    chk("d_done_sticky", state_w0, 3);

    // Reset in the middle of DRAIN, then a zero-count frame
    do_reset();
    for (int i = 0; i <= 16; i++) frame(3, i);
    rd_ready = 1'b1;
    repeat (11) tick();
    rd_ready = 1'b0;
    test_ending = 1'b1;
    tick();
    chk("e_pre_state", state_w0, 2);
    chk("e_pre_level", level_w0, 5);
    chk("e_pre_ovf", overflow_w0, 1);
    reset_n = 1'b0;
    frame(3, 'h77);
    reset_n = 1'b1;
    test_ending = 1'b0;
    chk("e_rst_state", state_w0, 0);
    chk("e_rst_level", level_w0, 0);
    chk("e_rst_rd_valid", rd_valid_w0, 0);
    chk("e_rst_ovf", overflow_w0, 0);
    chk("e_rst_rd_data", rd_data_w0, 0);
    frame(0, 'h5);
    chk("e_zero_level", level_w0, 0);
    chk("e_zero_state", state_w0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
